// File: rtl/audio_out_stage.sv
// Audio output stage: divides clk down to the sample rate, attenuates/mutes and
// saturates the synth sample to 24 bits, buffers it in a small FIFO and drains it to the codec.
module audio_out_stage #(
    parameter int unsigned CLK_DIV    = 1042,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] wave_in,
    input  logic [2:0]  volume,
    input  logic        mute,
    input  logic        audio_out_allowed,
    input  logic        clear_flags,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic [4:0]  fifo_level,
    output logic        overflow,
    output logic        clipped
);

    localparam int unsigned DIV_W    = 16;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned LEVEL_W  = 5;

    logic [DIV_W-1:0]    div_cnt;
    logic                tick_c;
    logic signed [31:0]  shifted_c;
    logic signed [31:0]  scaled_c;
    logic [SAMPLE_W-1:0] sat_c;
    logic                clip_c;
    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                full_c;
    logic                empty_c;
    logic                pop_c;
    logic                push_c;
    logic                drop_c;

    assign tick_c = enable && (div_cnt == DIV_W'(CLK_DIV - 1));

    // Sample-rate divider; held at zero while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (!enable || tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Attenuate, mute and saturate to the codec's 24-bit range.
    always_comb begin
        shifted_c = $signed(wave_in) >>> volume;
        scaled_c  = mute ? 32'sd0 : shifted_c;
        sat_c     = scaled_c[SAMPLE_W-1:0];
        clip_c    = 1'b0;
        if (scaled_c > 32'sd8388607) begin
            sat_c  = 24'h7FFFFF;
            clip_c = 1'b1;
        end else if (scaled_c < -32'sd8388608) begin
            sat_c  = 24'h800000;
            clip_c = 1'b1;
        end
    end

    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign full_c  = (fifo_level == LEVEL_W'(FIFO_DEPTH));
    assign empty_c = (fifo_level == '0);
    assign pop_c   = !empty_c && audio_out_allowed;
    assign push_c  = tick_c && (!full_c || pop_c);
    assign drop_c  = tick_c && full_c && !pop_c;

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= sat_c;
        end
    end

    // Pointers, occupancy, codec write port and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr                  <= '0;
            rd_ptr                  <= '0;
            fifo_level              <= '0;
            write_audio_out         <= 1'b0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
            overflow                <= 1'b0;
            clipped                 <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr                  <= rd_ptr + PTR_W'(1);
                left_channel_audio_out  <= {mem[rd_ptr], 8'h00};
                right_channel_audio_out <= {mem[rd_ptr], 8'h00};
            end
            case ({push_c, pop_c})
                2'b10:   fifo_level <= fifo_level + LEVEL_W'(1);
                2'b01:   fifo_level <= fifo_level - LEVEL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            write_audio_out <= pop_c;
            overflow        <= drop_c || (overflow && !clear_flags);
            clipped         <= (tick_c && clip_c) || (clipped && !clear_flags);
        end
    end

endmodule
